// File: rtl/arp_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : arp_tx_if
// Description : Bundles the reply-request input of the ARP transmit block
//               with the byte-serial AXI-stream path into the tx MAC FIFO.
//               master : the ARP transmitter (consumes requests, drives stream)
//               slave  : the environment (issues requests, sinks stream)
// Signals     : arp_dv_in, remote_mac[47:0], remote_ip[31:0]   request
//               tx_fifo_tvalid/tready/tdata[7:0]/tlast/tuser   stream
// Revision    : 1.0 - initial release
// ============================================================================
interface arp_tx_if;
    logic        arp_dv_in;
    logic [47:0] remote_mac;
    logic [31:0] remote_ip;
    logic        tx_fifo_tvalid;
    logic        tx_fifo_tready;
    logic [7:0]  tx_fifo_tdata;
    logic        tx_fifo_tlast;
    logic        tx_fifo_tuser;

    modport master (
        input  arp_dv_in,
        input  remote_mac,
        input  remote_ip,
        input  tx_fifo_tready,
        output tx_fifo_tvalid,
        output tx_fifo_tdata,
        output tx_fifo_tlast,
        output tx_fifo_tuser
    );

    modport slave (
        output arp_dv_in,
        output remote_mac,
        output remote_ip,
        output tx_fifo_tready,
        input  tx_fifo_tvalid,
        input  tx_fifo_tdata,
        input  tx_fifo_tlast,
        input  tx_fifo_tuser
    );
endinterface
`default_nettype wire

// File: rtl/arp_tx.sv
`default_nettype none
// ============================================================================
// Module      : arp_tx
// Description : ARP-reply frame generator. Accepts a one-cycle reply request
//               (requester MAC/IP), builds a 60-byte Ethernet ARP reply
//               (42 header bytes + zero padding, no FCS) and streams it
//               byte-serially over AXI-stream. One further request can be
//               held pending while a frame is in flight; latest wins.
// Ports       : clk, rst          clock, synchronous active-high reset
//               bus (master)      request in / AXI-stream out
//               busy              frame in flight or request pending
//               req_dropped       pulse: pending request overwritten
//               frames_sent[15:0] completed-frame counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module arp_tx #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0a_35_01_02_03,
    parameter logic [31:0] LOCAL_IP  = 32'h10_00_00_80
) (
    input  wire logic        clk,
    input  wire logic        rst,
    arp_tx_if.master         bus,
    output logic             busy,
    output logic             req_dropped,
    output logic [15:0]      frames_sent
);

    localparam logic [5:0] C_LAST_IDX = 6'd59;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [47:0] r_pend_mac;
    logic [31:0] r_pend_ip;
    logic        r_pend_valid;
    logic [47:0] r_cur_mac;
    logic [31:0] r_cur_ip;
    logic        r_req_dropped;
    logic [15:0] r_frames_sent;

    logic          w_consume;
    logic [479:0]  w_frame;
    logic [7:0]    w_byte;

    // The pending buffer is consumed only from IDLE; the transition to SEND
    // happens on the same edge.
    assign w_consume = (r_state == ST_IDLE) && r_pend_valid;

    // Whole frame as one vector, byte 0 in the top bits.
    assign w_frame = {r_cur_mac, LOCAL_MAC,
                      16'h0806,            // ethertype ARP
                      16'h0001,            // htype Ethernet
                      16'h0800,            // ptype IPv4
                      8'h06, 8'h04,        // hlen, plen
                      16'h0002,            // opcode reply
                      LOCAL_MAC, LOCAL_IP,
                      r_cur_mac, r_cur_ip,
                      144'h0};             // pad bytes 42..59

    assign w_byte = w_frame[(9'd479 - {r_idx, 3'b000}) -: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 6'd0;
            r_pend_mac    <= 48'h0;
            r_pend_ip     <= 32'h0;
            r_pend_valid  <= 1'b0;
            r_cur_mac     <= 48'h0;
            r_cur_ip      <= 32'h0;
            r_req_dropped <= 1'b0;
            r_frames_sent <= 16'h0;
        end else begin
            // A new request always lands in the pending slot; overwriting an
            // unconsumed one loses it.
            r_req_dropped <= bus.arp_dv_in && r_pend_valid && !w_consume;
            if (bus.arp_dv_in) begin
                r_pend_mac   <= bus.remote_mac;
                r_pend_ip    <= bus.remote_ip;
                r_pend_valid <= 1'b1;
            end else if (w_consume) begin
                r_pend_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend_valid) begin
                        r_cur_mac <= r_pend_mac;
                        r_cur_ip  <= r_pend_ip;
                        r_idx     <= 6'd0;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_fifo_tready) begin
                        if (r_idx == C_LAST_IDX) begin
                            r_idx         <= 6'd0;
                            r_frames_sent <= r_frames_sent + 16'd1;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stream outputs derive from registered state only, so they hold steady
    // across stalls and drop the cycle after reset is sampled.
    assign bus.tx_fifo_tvalid = (r_state == ST_SEND);
    assign bus.tx_fifo_tdata  = (r_state == ST_SEND) ? w_byte : 8'h00;
    assign bus.tx_fifo_tlast  = (r_state == ST_SEND) && (r_idx == C_LAST_IDX);
    assign bus.tx_fifo_tuser  = 1'b0;

    assign busy        = (r_state == ST_SEND) || r_pend_valid;
    assign req_dropped = r_req_dropped;
    assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_arp_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_arp_tx
// Description : Scoreboard bench for arp_tx. A transaction-level model turns
//               requests into expected frames (built byte by byte from the
//               ARP reply layout) and queues them; a negedge monitor pops and
//               compares every presented beat plus the status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_tx;

    localparam logic [47:0] C_LMAC = 48'h00_0a_35_01_02_03;
    localparam logic [31:0] C_LIP  = 32'h10_00_00_80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        req_dropped;
    logic [15:0] frames_sent;

    arp_tx_if bus();

    arp_tx #(.LOCAL_MAC(C_LMAC), .LOCAL_IP(C_LIP)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .req_dropped (req_dropped),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference frame construction, straight from the byte layout table
    // ------------------------------------------------------------------
    function automatic logic [479:0] build_frame(input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0]   b [60];
        logic [479:0] f;
        for (int i = 0; i < 60; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = mac[47 - 8*i -: 8];
            b[6 + i]  = C_LMAC[47 - 8*i -: 8];
            b[22 + i] = C_LMAC[47 - 8*i -: 8];
            b[32 + i] = mac[47 - 8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
        b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
        b[20] = 8'h00; b[21] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            b[28 + i] = C_LIP[31 - 8*i -: 8];
            b[38 + i] = ip[31 - 8*i -: 8];
        end
        f = '0;
        for (int i = 0; i < 60; i++) f[i*8 +: 8] = b[i];
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: one pending slot, one frame in flight
    // ------------------------------------------------------------------
    logic [479:0] exp_q[$];
    bit           m_send   = 1'b0;
    int           m_beats  = 0;
    bit           m_pend   = 1'b0;
    logic [47:0]  m_pmac   = '0;
    logic [31:0]  m_pip    = '0;
    bit           m_drop   = 1'b0;
    logic [15:0]  m_frames = '0;
    int           m_rst_cnt = 0;
    bit           preload  = 1'b0;

    always @(posedge clk) begin
        bit take;
        if (rst) begin
            m_send = 1'b0; m_beats = 0; m_pend = 1'b0; m_drop = 1'b0; m_frames = '0;
            m_rst_cnt++;
        end else begin
            take   = !m_send && m_pend;
            m_drop = bus.arp_dv_in && m_pend && !take;
            if (m_send) begin
                if (bus.tx_fifo_tready) begin
                    m_beats++;
                    if (m_beats == 60) begin
                        m_send = 1'b0;
                        m_frames++;
                    end
                end
            end else if (take) begin
                m_send  = 1'b1;
                m_beats = 0;
                exp_q.push_back(build_frame(m_pmac, m_pip));
            end
            if (bus.arp_dv_in) begin
                m_pend = 1'b1; m_pmac = bus.remote_mac; m_pip = bus.remote_ip;
            end else if (take) begin
                m_pend = 1'b0;
            end
            if (preload) m_frames = 16'hFFFF;
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;
    int  mon_beat = 0;
    int  mon_done = 0;
    int  mon_drops = 0;
    int  mon_rst_seen = 0;
    int  chk_req = 0;
    int  chk_seen = 0;
    bit  chk_counts = 1'b1;
    int  exp_done = 0, exp_drops = 0;
    logic [15:0] exp_fs = '0;
    int  timeouts = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t beat=%0d)", n, act, want, $time, mon_beat);
        end
    endtask

    always @(negedge clk) begin
        if (m_rst_cnt != mon_rst_seen) begin
            mon_rst_seen = m_rst_cnt;
            exp_q.delete();
            mon_beat = 0;
        end
        if (mon_en) begin
            chk("tvalid", {31'b0, bus.tx_fifo_tvalid}, {31'b0, m_send});
            chk("tuser", {31'b0, bus.tx_fifo_tuser}, 32'd0);
            chk("busy", {31'b0, busy}, {31'b0, (m_send || m_pend)});
            chk("req_dropped", {31'b0, req_dropped}, {31'b0, m_drop});
            if (!preload) chk("frames_sent", {16'b0, frames_sent}, {16'b0, m_frames});
            if (req_dropped) mon_drops++;
            if (bus.tx_fifo_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_without_frame", 32'd1, 32'd0);
                end else begin
                    chk("tdata", {24'b0, bus.tx_fifo_tdata}, {24'b0, exp_q[0][mon_beat*8 +: 8]});
                    chk("tlast", {31'b0, bus.tx_fifo_tlast}, {31'b0, (mon_beat == 59)});
                    if (bus.tx_fifo_tready) begin
                        if (mon_beat == 59) begin
                            void'(exp_q.pop_front());
                            mon_beat = 0;
                            mon_done++;
                        end else begin
                            mon_beat++;
                        end
                    end
                end
            end else begin
                chk("tdata_idle", {24'b0, bus.tx_fifo_tdata}, 32'd0);
                chk("tlast_idle", {31'b0, bus.tx_fifo_tlast}, 32'd0);
            end
            if (chk_req != chk_seen) begin
                chk_seen = chk_req;
                chk("timeouts", timeouts, 32'd0);
                if (chk_counts) begin
                    chk("frames_done", mon_done, exp_done);
                    chk("drop_pulses", mon_drops, exp_drops);
                    chk("frames_sent_end", {16'b0, frames_sent}, {16'b0, exp_fs});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit rdy_mode = 1'b0;

    initial begin
        bus.tx_fifo_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_fifo_tready = rdy_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [47:0] mac, input logic [31:0] ip);
        bus.arp_dv_in  = 1'b1;
        bus.remote_mac = mac;
        bus.remote_ip  = ip;
        tick();
        bus.arp_dv_in  = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((busy || bus.tx_fifo_tvalid) && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) timeouts++;
        tick();
    endtask

    task automatic end_check(input int d, input int dr, input logic [15:0] fs);
        exp_done  = d;
        exp_drops = dr;
        exp_fs    = fs;
        chk_req++;
        tick();
        tick();
    endtask

    initial begin
        int n;
        bus.arp_dv_in  = 1'b0;
        bus.remote_mac = '0;
        bus.remote_ip  = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single reply, sink always ready
        send_req(48'h00_11_22_33_44_55, 32'h10_00_00_01);
        wait_idle();
        end_check(1, 0, 16'd1);

        // Same request under ~30% ready
        rdy_mode = 1'b1;
        send_req(48'h00_11_22_33_44_55, 32'h10_00_00_01);
        wait_idle();
        rdy_mode = 1'b0;
        end_check(2, 0, 16'd2);

        // Back-to-back: second request 10 cycles after the first
        send_req(48'h00_11_22_33_44_55, 32'h10_00_00_01);
        repeat (9) tick();
        send_req(48'h00_11_22_33_44_66, 32'h10_00_00_02);
        wait_idle();
        end_check(4, 0, 16'd4);

        // Overflow: three requests during frame 1, the middle one is lost
        send_req(48'h00_11_22_33_44_55, 32'h10_00_00_01);
        repeat (5) tick();
        send_req(48'h00_11_22_33_44_66, 32'h10_00_00_02);
        repeat (5) tick();
        send_req(48'h00_11_22_33_44_77, 32'h10_00_00_03);
        wait_idle();
        end_check(6, 1, 16'd6);

        // Reset at beat 20 with a request pending
        send_req(48'h00_aa_bb_cc_dd_ee, 32'h10_00_00_04);
        repeat (4) tick();
        send_req(48'h00_aa_bb_cc_dd_ef, 32'h10_00_00_05);
        n = 0;
        while (mon_beat != 20 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeouts++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        end_check(6, 1, 16'd0);
        send_req(48'h00_12_34_56_78_9a, 32'h10_00_00_06);
        wait_idle();
        end_check(7, 1, 16'd1);

        // Counter wrap from a preloaded 0xFFFF
        force dut.r_frames_sent = 16'hFFFF;
        preload = 1'b1;
        tick();
        release dut.r_frames_sent;
        preload = 1'b0;
        tick();
        send_req(48'h00_11_22_33_44_55, 32'h10_00_00_07);
        wait_idle();
        end_check(8, 1, 16'd0);

        // Random requests, random gaps, random backpressure
        rdy_mode   = 1'b1;
        chk_counts = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_req({$urandom(), $urandom()} , $urandom());
            repeat ($urandom_range(0, 150)) tick();
        end
        wait_idle();
        end_check(0, 0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/arp_tx.md
# arp_tx

Transmit side of the ARP responder. Takes the one-cycle reply request produced by the ARP receive path, which carries the requester's MAC and IP. Builds a complete ARP-reply Ethernet frame: 42 header bytes plus zero padding to a 60-byte minimum, with no FCS because the MAC appends it. Streams the frame byte-serially into the tx MAC FIFO over AXI-stream, honouring backpressure, and buffers one further request while a frame is in flight.

## Interface
- `local_mac`, 48'h00_0a_35_01_02_03, our MAC; used as source MAC and sender hardware address.
- `local_ip`, 32'h10_00_00_80, our IPv4 address; used as sender protocol address.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset.
- `arp_dv_in`  in  1  one-cycle request pulse; `remote_mac`/`remote_ip` valid on this cycle.
- `remote_mac`  in  48  requester MAC.
- `remote_ip`  in  32  requester IP.
- `tx_fifo_tvalid`  out  1  byte valid.
- `tx_fifo_tready`  in  1  FIFO accepts byte.
- `tx_fifo_tdata`  out  8  frame byte.
- `tx_fifo_tlast`  out  1  high on byte 59 only.
- `tx_fifo_tuser`  out  1  tied 0.
- `busy`  out  1  high when state is SEND or a request is pending.
- `req_dropped`  out  1  one-cycle pulse when a pending request is overwritten.
- `frames_sent`  out  16  count of completed frames; wraps at 0xFFFF→0.

## Operation
- **Pending buffer**
  - `pend_mac`/`pend_ip`/`pend_valid`.
  - `arp_dv_in` always writes the pending buffer and sets `pend_valid`. The set has priority over a same-cycle consume.
  - If `pend_valid`=1 and the buffer is not consumed on that cycle, the old request is lost: latest wins and `req_dropped` pulses.
- **Current registers**: `cur_mac`/`cur_ip`, held constant for the whole of SEND.
- **State IDLE**
  - Outputs: `tvalid`=0, `tdata`=0, `tlast`=0.
  - If `pend_valid`: load cur from pend, clear `pend_valid` (unless `arp_dv_in` on the same cycle), `idx`<=0, go to SEND.
- **State SEND**
  - `tvalid`=1 and `tdata`=byte[`idx`], combinational from `cur_*` and the parameters.
  - On `tvalid & tready`: `idx`<=`idx`+1.
  - When the accepted byte is `idx`=59: `frames_sent`++, go to IDLE.
- **Frame bytes, by index**
  - 0–5 `cur_mac`, MSB first.
  - 6–11 `local_mac`.
  - 12–13 0x08,0x06.
  - 14–15 0x00,0x01.
  - 16–17 0x08,0x00.
  - 18 0x06; 19 0x04.
  - 20–21 0x00,0x02 (reply).
  - 22–27 `local_mac`.
  - 28–31 `local_ip`.
  - 32–37 `cur_mac`.
  - 38–41 `cur_ip`.
  - 42–59 0x00.
- **Widths**
  - `idx` is 6 bits; values 60–63 are unreachable.
  - `frames_sent` is 16-bit modular.

## Timing
- **Reset values**
  - state IDLE, `idx`=0, `pend_valid`=0.
  - `tvalid`=0, `tlast`=0, `tdata`=0, `tuser`=0.
  - `busy`=0, `req_dropped`=0, `frames_sent`=0.
- **Latency**: `arp_dv_in` at cycle N → `pend_valid` at N+1 → first byte with `tvalid`=1 at N+2 when idle.
- **AXI rules**
  - `tdata`/`tlast` are stable while `tvalid & !tready`.
  - `tvalid` never drops mid-frame except on reset.
  - With `tready` held at 1, a frame occupies exactly 60 cycles.
- **Back-to-back**: at least one IDLE cycle between frames. The next frame's `tvalid` rises 2 cycles after the previous `tlast` beat.
- **Simultaneous events**
  - `arp_dv_in` on the IDLE cycle that consumes pend: the consumed request is sent and the new one remains pending. No drop.
  - `arp_dv_in` while `pend_valid`=1 and in SEND: overwrite, and `req_dropped`=1 on the next cycle.
- **Reset mid-frame**
  - Frame abandoned, `tvalid`=0 the cycle after `rst` is sampled, no `tlast` issued.
  - Pending request discarded; `frames_sent` cleared.
- `busy` is registered-state derived and rises the cycle after `arp_dv_in`.

## Test plan
- **Single reply**
  - Stimulus: `tready`=1; `arp_dv_in` with remote_mac=0x001122334455, remote_ip=0x10000001.
  - Required: 60 beats starting 2 cycles later.
  - Bytes 0–5 = 00 11 22 33 44 55; 12–13 = 08 06; 20–21 = 00 02; 28–31 = 10 00 00 80; 38–41 = 10 00 00 01; 42–59 = 00.
  - `tlast` only on beat 59; `frames_sent`=1.
- **Backpressure**
  - Stimulus: `tready` random at 30% duty.
  - Required: same byte sequence; `tdata`/`tlast` unchanged across stalls; no `tvalid` gap mid-frame.
- **Back-to-back**
  - Stimulus: two requests (IP …01, then …02), the second 10 cycles after the first.
  - Required: two complete frames in order; exactly one idle cycle between them; `frames_sent`=2; no `req_dropped`.
- **Overflow**
  - Stimulus: three requests (…01, …02, …03) during frame 1.
  - Required: `req_dropped` pulses once; the frames sent carry …01 then …03.
- **Reset mid-frame**
  - Stimulus: `rst` asserted at beat 20 with a request pending.
  - Required: `tvalid`=0 next cycle; no further beats; `busy`=0; `frames_sent`=0. A new request afterwards produces a full, correct 60-byte frame.
- **Counter wrap**
  - Stimulus: force/preload `frames_sent` to 0xFFFF, then send one frame.
  - Required: `frames_sent` reads 0x0000.
